serial_subtractor5b: RTL

//  Bit-serial ripple-borrow subtractor: computes D = A - B - BIN over WIDTH clock cycles, one bit per cycle, LSB first.

---
 rtl/serial_subtractor5b_pkg.sv | 15 +
 rtl/serial_subtractor5b_full_subtractor1b.sv | 15 +
 rtl/serial_subtractor5b.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor5b_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
// Holds the default operand width and the FSM state type used by the top level.
package serial_subtractor5b_pkg;

  // Default operand/result width in bits
  localparam int SUB_W = 5;

  // Controller states: idle, shifting bits, result-valid cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor5b_full_subtractor1b.sv
// One-bit full subtractor: di = ai - bi - br, with borrow-out.
// Pure combinational cell; the serial top level reuses it for every bit position.
module full_subtractor1b (
  input  logic ai,
  input  logic bi,
  input  logic br,
  output logic di,
  output logic br_out
);

  // A borrow leaves this bit when bi exceeds ai, or when they match and a borrow came in
  assign di     = ai ^ bi ^ br;
  assign br_out = (~ai & bi) | (~(ai ^ bi) & br);

endmodule

// File: rtl/serial_subtractor5b.sv
// Bit-serial ripple-borrow subtractor: d = a - b - b_in, one bit per clock, LSB first.
// Optional feature macro: SUB_OVF_FLAG_EN adds the signed-overflow output ovf and the
// operand-MSB latch it needs; without it the ovf port does not exist.
module serial_subtractor5b
  import serial_subtractor5b_pkg::*;
#(
  parameter int WIDTH = SUB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bOut;
  logic             w_di;
  logic             w_brNext;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_resShift;
`ifdef SUB_OVF_FLAG_EN
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_ovf;
`endif

  full_subtractor1b u_fullSub (
    .ai     (r_a[0]),
    .bi     (r_b[0]),
    .br     (r_br),
    .di     (w_di),
    .br_out (w_brNext)
  );

  // A request is taken whenever no operation is in flight, including the done cycle
  assign w_accept   = start && (r_state != ST_RUN);
  assign w_last     = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_resShift = {w_di, r_res};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  // Next-state logic: run for WIDTH bit cycles, then present the result for one cycle
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_stateNext = ST_RUN;
      ST_RUN:  if (w_last) w_stateNext = ST_DONE;
      ST_DONE: w_stateNext = start ? ST_RUN : ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle, publish on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_d    <= '0;
      r_bOut <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      r_aMsb <= 1'b0;
      r_bMsb <= 1'b0;
      r_ovf  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= b_in;
      r_cnt <= '0;
`ifdef SUB_OVF_FLAG_EN
      r_aMsb <= a[WIDTH-1];
      r_bMsb <= b[WIDTH-1];
`endif
    end else if (r_state == ST_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_resShift[WIDTH-1:1];
      r_br  <= w_brNext;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_d    <= w_resShift;
        r_bOut <= w_brNext;
`ifdef SUB_OVF_FLAG_EN
        r_ovf  <= (r_aMsb ^ r_bMsb) & (r_aMsb ^ w_di);
`endif
      end
    end
  end

  assign d     = r_d;
  assign b_out = r_bOut;
`ifdef SUB_OVF_FLAG_EN
  assign ovf   = r_ovf;
`endif

endmodule
